// File: rtl/qpsk_pkg.sv
// Shared types and helpers for the QPSK bit framer.
// Dibits are stored {Q,I}.
package qpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD
    } framer_state_t;

    typedef logic [1:0] dibit_t;

    localparam logic [15:0] PREAMBLE_DEFAULT = 16'hF0A5;

    function automatic logic [1:0] gray2delta(input dibit_t d);
        logic [1:0] r;
        unique case (d)
            2'b00:   r = 2'd0;
            2'b01:   r = 2'd1;
            2'b11:   r = 2'd2;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic dibit_t phase2gray(input logic [1:0] p);
        dibit_t r;
        unique case (p)
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b01;
            2'd2:    r = 2'b11;
            default: r = 2'b10;
        endcase
        return r;
    endfunction

    // Symbol k of a word, LSB-first: {bit[2k+1], bit[2k]} = {Q,I}.
    function automatic dibit_t word_dibit(
        input logic [15:0] w,
        input logic [2:0]  k
    );
        return w[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/qpsk_diff_enc.sv
// Differential Gray encoder: accumulates phase from each raw dibit.
// restart forces the phase base to zero for the symbol loaded that cycle.
module qpsk_diff_enc
    import qpsk_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  dibit_t dibit,
    input  logic   advance,
    input  logic   restart,
    output dibit_t dibit_o
);

    logic [1:0] phase_q;
    logic [1:0] phase_d;
    logic [1:0] base;
    logic [1:0] sum;

    always_comb begin
        base    = restart ? 2'd0 : phase_q;
        sum     = base + gray2delta(dibit);
        dibit_o = phase2gray(sum);
        phase_d = advance ? sum : base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/qpsk_bit_framer.sv
// Byte stream to QPSK dibit framer with preamble insertion.
// Output register holds the symbol on display; loads only on handshake.
module qpsk_bit_framer
    import qpsk_pkg::*;
#(
    parameter int          FRAME_BYTES = 32,
    parameter logic [15:0] PREAMBLE    = PREAMBLE_DEFAULT,
    parameter bit          DIFF_EN     = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_I,
    output logic       out_Q,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int CW = $clog2(FRAME_BYTES + 1);
    localparam logic [CW-1:0] LAST_BYTE = CW'(FRAME_BYTES);

    framer_state_t state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    byte_q, byte_d;
    dibit_t        sym_q, sym_d;
    logic          valid_q, valid_d;

    dibit_t raw;
    dibit_t enc;
    logic   load;
    logic   restart;
    logic   take;
    logic   start;
    logic   fire;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        byte_d   = byte_q;
        valid_d  = valid_q;
        raw      = '0;
        load     = 1'b0;
        restart  = 1'b0;
        take     = 1'b0;
        start    = 1'b0;
        in_ready = 1'b0;
        fire     = valid_q && out_ready;

        unique case (state_q)
            ST_IDLE: begin
                start = in_valid;
            end
            ST_PREAMBLE: begin
                if (fire) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_PAYLOAD;
                        take    = 1'b1;
                    end else begin
                        load  = 1'b1;
                        idx_d = idx_q + 3'd1;
                        raw   = word_dibit(PREAMBLE, idx_q + 3'd1);
                    end
                end
            end
            ST_PAYLOAD: begin
                if (!valid_q) begin
                    take = 1'b1;
                end else if (fire) begin
                    if (idx_q != 3'd3) begin
                        load  = 1'b1;
                        idx_d = idx_q + 3'd1;
                        raw   = word_dibit({8'h00, byte_q}, idx_q + 3'd1);
                    end else if (cnt_q == LAST_BYTE) begin
                        if (in_valid) begin
                            start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        take = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        if (start) begin
            state_d = ST_PREAMBLE;
            restart = 1'b1;
            load    = 1'b1;
            idx_d   = 3'd0;
            cnt_d   = '0;
            raw     = word_dibit(PREAMBLE, 3'd0);
        end

        // Byte slot free: accept now, or leave a bubble if none offered.
        if (take) begin
            in_ready = 1'b1;
            if (in_valid) begin
                load   = 1'b1;
                byte_d = in_data;
                idx_d  = 3'd0;
                cnt_d  = cnt_q + CW'(1);
                raw    = in_data[1:0];
            end else begin
                valid_d = 1'b0;
            end
        end

        if (load) begin
            valid_d = 1'b1;
        end
        sym_d = load ? enc : sym_q;
    end

    generate
        if (DIFF_EN) begin : g_diff
            qpsk_diff_enc u_enc (
                .clk     (clk),
                .rst     (rst),
                .dibit   (raw),
                .advance (load),
                .restart (restart),
                .dibit_o (enc)
            );
        end else begin : g_raw
            logic unused_restart;
            assign unused_restart = restart;
            assign enc = raw;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            byte_q  <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
        end
    end

    assign out_I     = sym_q[0];
    assign out_Q     = sym_q[1];
    assign out_valid = valid_q;

endmodule
